// File: rtl/gray_to_bin.sv
// gray_to_bin
//   Converts a reflected-binary (Gray) code word to natural binary.
//   A combinational result is available in the same cycle. A registered,
//   valid-qualified result follows one cycle later. Consecutive valid words
//   that differ in more than one bit are flagged as illegal Gray steps.
//
// Ports
//   clk         in   1      rising-edge clock
//   rst         in   1      synchronous reset, active-high
//   gray        in   WIDTH  Gray-coded input word
//   gray_valid  in   1      gray is valid this cycle
//   binary      out  WIDTH  combinational binary of gray (ignores rst/valid)
//   bin_q       out  WIDTH  registered binary of the last valid gray
//   bin_valid   out  1      one-cycle pulse: bin_q updated this cycle
//   step_err    out  1      registered; illegal Gray step, only with bin_valid
module gray_to_bin #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gray,
    input  logic             gray_valid,
    output logic [WIDTH-1:0] binary,
    output logic [WIDTH-1:0] bin_q,
    output logic             bin_valid,
    output logic             step_err
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1'b1);

    // Prefix XOR from the MSB down: each binary bit folds in one more Gray bit.
    function automatic logic [WIDTH-1:0] gray_decode(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = g;
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // True when more than one bit is set. Clearing the lowest set bit leaves
    // something behind only if a second bit was set.
    function automatic logic multi_bit(input logic [WIDTH-1:0] d);
        return ((d & (d - ONE)) != ZERO);
    endfunction

    logic [WIDTH-1:0] binary_s;
    logic             step_err_s;
    logic [WIDTH-1:0] bin_q_r;
    logic             bin_valid_r;
    logic             step_err_r;
    logic [WIDTH-1:0] prev_gray_r;
    logic             prev_ok_r;

    // Same-cycle Gray decode.
    always_comb begin
        binary_s = gray_decode(gray);
    end

    // Step check against the previous accepted word. No previous word means no error.
    always_comb begin
        step_err_s = 1'b0;
        if (gray_valid && prev_ok_r) begin
            step_err_s = multi_bit(gray ^ prev_gray_r);
        end else begin
            step_err_s = 1'b0;
        end
    end

    // Output registers and previous-word store. Reset drops a coincident valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q_r     <= ZERO;
            bin_valid_r <= 1'b0;
            step_err_r  <= 1'b0;
            prev_gray_r <= ZERO;
            prev_ok_r   <= 1'b0;
        end else if (gray_valid) begin
            bin_q_r     <= binary_s;
            bin_valid_r <= 1'b1;
            step_err_r  <= step_err_s;
            prev_gray_r <= gray;
            prev_ok_r   <= 1'b1;
        end else begin
            bin_valid_r <= 1'b0;
            step_err_r  <= 1'b0;
        end
    end

    assign binary    = binary_s;
    assign bin_q     = bin_q_r;
    assign bin_valid = bin_valid_r;
    assign step_err  = step_err_r;

endmodule

// File: tb/tb_gray_to_bin.sv
module tb_gray_to_bin;

    logic       clk;
    logic       rst;
    logic [2:0] gray;
    logic       gray_valid;
    logic [2:0] binary;
    logic [2:0] bin_q;
    logic       bin_valid;
    logic       step_err;

    logic       rst8;
    logic [7:0] gray8;
    logic       gray_valid8;
    logic [7:0] binary8;
    logic [7:0] bin_q8;
    logic       bin_valid8;
    logic       step_err8;

    int total;
    int bad;

    gray_to_bin #(.WIDTH(3)) dut (
        .clk(clk), .rst(rst), .gray(gray), .gray_valid(gray_valid),
        .binary(binary), .bin_q(bin_q), .bin_valid(bin_valid), .step_err(step_err)
    );

    gray_to_bin #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .gray(gray8), .gray_valid(gray_valid8),
        .binary(binary8), .bin_q(bin_q8), .bin_valid(bin_valid8), .step_err(step_err8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       v;
        logic [2:0] g;
        logic [2:0] q;
        logic       ev;
        logic       ee;
    } vec_t;

    typedef struct {
        logic [2:0] q;
        logic       v;
        logic       e;
    } exp_t;

    vec_t vecs[22];
    exp_t sb[$];

    // Reference decode: binary bit i is the XOR of all Gray bits at or above i.
    function automatic logic [7:0] ref_bin(input logic [7:0] g, input int w);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < w; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    initial begin
        exp_t e;
        exp_t got;
        logic [7:0] g8;
        total = 0;
        bad   = 0;

        //            rst   valid gray    bin_q   bvalid err
        vecs[0]  = '{1'b1, 1'b0, 3'b000, 3'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 3'b000, 3'd0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 3'b001, 3'd1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 3'b011, 3'd2, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 3'b010, 3'd3, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 3'b110, 3'd4, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 3'b111, 3'd5, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 3'b101, 3'd6, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 3'b100, 3'd7, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 3'b000, 3'd0, 1'b1, 1'b0}; // wrap
        vecs[10] = '{1'b0, 1'b1, 3'b011, 3'd2, 1'b1, 1'b1}; // two-bit jump
        vecs[11] = '{1'b0, 1'b1, 3'b010, 3'd3, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 3'b110, 3'd4, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 3'b011, 3'd4, 1'b0, 1'b0}; // gap, gray ignored
        vecs[14] = '{1'b0, 1'b0, 3'b000, 3'd4, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 3'b111, 3'd5, 1'b1, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 3'b101, 3'd0, 1'b0, 1'b0}; // reset drops input
        vecs[17] = '{1'b0, 1'b1, 3'b111, 3'd5, 1'b1, 1'b0}; // first after reset
        vecs[18] = '{1'b0, 1'b1, 3'b100, 3'd7, 1'b1, 1'b1};
        vecs[19] = '{1'b1, 1'b0, 3'b000, 3'd0, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 1'b1, 3'b011, 3'd2, 1'b1, 1'b0}; // first after reset
        vecs[21] = '{1'b0, 1'b1, 3'b000, 3'd0, 1'b1, 1'b1};

        rst         = 1'b1;
        gray        = 3'b000;
        gray_valid  = 1'b0;
        rst8        = 1'b1;
        gray8       = 8'h00;
        gray_valid8 = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < 22; k++) begin
            rst        = vecs[k].r;
            gray_valid = vecs[k].v;
            gray       = vecs[k].g;
            e.q = vecs[k].q;
            e.v = vecs[k].ev;
            e.e = vecs[k].ee;
            sb.push_back(e);
            #1;
            chk($sformatf("binary[%0d]", k), {5'b00000, binary}, ref_bin({5'b00000, gray}, 3));
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 8'h01, 8'h00);
            end else begin
                got = sb.pop_front();
                chk($sformatf("bin_q[%0d]", k), {5'b00000, bin_q}, {5'b00000, got.q});
                chk($sformatf("bin_valid[%0d]", k), {7'b0000000, bin_valid}, {7'b0000000, got.v});
                chk($sformatf("step_err[%0d]", k), {7'b0000000, step_err}, {7'b0000000, got.e});
            end
        end
        rst        = 1'b0;
        gray_valid = 1'b0;

        // WIDTH=8 spot values, then the full sweep against the reference formula.
        gray8 = 8'h80; #1; chk("w8_80", binary8, 8'hFF);
        gray8 = 8'hC0; #1; chk("w8_C0", binary8, 8'h80);
        gray8 = 8'h01; #1; chk("w8_01", binary8, 8'h01);
        for (int i = 0; i < 256; i++) begin
            g8    = i[7:0];
            gray8 = g8;
            #1;
            chk($sformatf("w8_sweep_%0h", g8), binary8, ref_bin(g8, 8));
        end

        // WIDTH=8 registered path: one valid word after reset.
        rst8        = 1'b0;
        gray8       = 8'hC0;
        gray_valid8 = 1'b1;
        @(posedge clk);
        #1;
        gray_valid8 = 1'b0;
        chk("w8_bin_q", bin_q8, 8'h80);
        chk("w8_bin_valid", {7'b0000000, bin_valid8}, 8'h01);
        chk("w8_step_err", {7'b0000000, step_err8}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog keeps the run bounded.
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
